// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle signed multiply / divide unit.
// Multiply uses radix-2 Booth recoding, one step per clock.
// Divide uses restoring division on magnitudes, one quotient bit per clock.
// A final FIX step then applies the quotient and remainder signs.
// The 64-bit result lands in z_high/z_low and holds until the next write.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] z_high,
    output logic [WIDTH-1:0] z_low
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   counter_r;
    logic               last_step_s;
    logic               busy_next_s;
    logic               done_next_s;

    // Booth datapath: {upper partial product, multiplier, q(-1)}
    logic [2*WIDTH:0]   acc_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH:0]     booth_ext_s;
    logic [WIDTH:0]     mcand_ext_s;
    logic [WIDTH:0]     booth_sum_s;
    logic [2*WIDTH:0]   booth_next_s;

    // Restoring divider datapath on unsigned magnitudes
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   divisor_r;
    logic               a_neg_r;
    logic               sign_diff_r;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_diff_s;
    logic               div_neg_s;
    logic [WIDTH-1:0]   rem_next_s;
    logic [WIDTH-1:0]   quo_next_s;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] m;
        if (v[WIDTH-1]) begin
            m = {WIDTH{1'b0}} - v;
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Conditional two's-complement negation used by the FIX step.
    function automatic logic [WIDTH-1:0] neg_if_f(input logic [WIDTH-1:0] v, input logic neg);
        logic [WIDTH-1:0] r;
        if (neg) begin
            r = {WIDTH{1'b0}} - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    assign last_step_s = (counter_r == CNT_W'(WIDTH - 1));

    // State register: clear forces IDLE and overrides any operation in flight.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (!op) begin
                        state_next_s = ST_MUL;
                    end else if (b_in == {WIDTH{1'b0}}) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_DIV;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (last_step_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_MUL;
                end
            end
            ST_DIV: begin
                if (last_step_s) begin
                    state_next_s = ST_FIX;
                end else begin
                    state_next_s = ST_DIV;
                end
            end
            ST_FIX:  state_next_s = ST_DONE;
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Status decode from the upcoming state so busy/done can be registered.
    always_comb begin
        busy_next_s = 1'b0;
        done_next_s = 1'b0;
        case (state_next_s)
            ST_MUL, ST_DIV, ST_FIX: busy_next_s = 1'b1;
            ST_DONE:                done_next_s = 1'b1;
            default: begin
                busy_next_s = 1'b0;
                done_next_s = 1'b0;
            end
        endcase
    end

    // Registered status outputs; they track the state register exactly.
    always_ff @(posedge clock) begin
        if (clear) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_next_s;
            done <= done_next_s;
        end
    end

    // One Booth step: add/subtract the multiplicand, then arithmetic shift right.
    // The sum is kept one bit wider so -2^(W-1) operands cannot overflow.
    always_comb begin
        booth_ext_s = {acc_r[2*WIDTH], acc_r[2*WIDTH:WIDTH+1]};
        mcand_ext_s = {mcand_r[WIDTH-1], mcand_r};
        case (acc_r[1:0])
            2'b01:   booth_sum_s = booth_ext_s + mcand_ext_s;
            2'b10:   booth_sum_s = booth_ext_s - mcand_ext_s;
            default: booth_sum_s = booth_ext_s;
        endcase
        booth_next_s = {booth_sum_s, acc_r[WIDTH:1]};
    end

    // One restoring-division step: trial subtract, keep or restore, shift in quotient bit.
    always_comb begin
        div_shift_s = {rem_r, quo_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, divisor_r};
        div_neg_s   = div_diff_s[WIDTH];
        if (div_neg_s) begin
            rem_next_s = div_shift_s[WIDTH-1:0];
        end else begin
            rem_next_s = div_diff_s[WIDTH-1:0];
        end
        quo_next_s = {quo_r[WIDTH-2:0], ~div_neg_s};
        quo_fix_s  = neg_if_f(quo_r, sign_diff_r);
        rem_fix_s  = neg_if_f(rem_r, a_neg_r);
    end

    // Datapath and result registers: operand latch on accepted start, iterate, write result.
    always_ff @(posedge clock) begin
        if (clear) begin
            counter_r   <= {CNT_W{1'b0}};
            acc_r       <= {(2*WIDTH+1){1'b0}};
            mcand_r     <= {WIDTH{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            quo_r       <= {WIDTH{1'b0}};
            divisor_r   <= {WIDTH{1'b0}};
            a_neg_r     <= 1'b0;
            sign_diff_r <= 1'b0;
            div_by_zero <= 1'b0;
            z_high      <= {WIDTH{1'b0}};
            z_low       <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        counter_r   <= {CNT_W{1'b0}};
                        div_by_zero <= 1'b0;
                        if (!op) begin
                            acc_r   <= {{WIDTH{1'b0}}, b_in, 1'b0};
                            mcand_r <= a_in;
                        end else if (b_in == {WIDTH{1'b0}}) begin
                            z_low       <= {WIDTH{1'b1}};
                            z_high      <= a_in;
                            div_by_zero <= 1'b1;
                        end else begin
                            rem_r       <= {WIDTH{1'b0}};
                            quo_r       <= mag_f(a_in);
                            divisor_r   <= mag_f(b_in);
                            a_neg_r     <= a_in[WIDTH-1];
                            sign_diff_r <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                        end
                    end
                end
                ST_MUL: begin
                    acc_r     <= booth_next_s;
                    counter_r <= counter_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (last_step_s) begin
                        z_high <= booth_next_s[2*WIDTH:WIDTH+1];
                        z_low  <= booth_next_s[WIDTH:1];
                    end
                end
                ST_DIV: begin
                    rem_r     <= rem_next_s;
                    quo_r     <= quo_next_s;
                    counter_r <= counter_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                ST_FIX: begin
                    z_low  <= quo_fix_s;
                    z_high <= rem_fix_s;
                end
                ST_DONE: begin
                    counter_r <= counter_r;
                end
                default: begin
                    counter_r <= counter_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: self-checking bench for mul_div_unit.
// Expected results come from plain 64-bit signed arithmetic in ref_model.
module tb_mul_div_unit;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic        op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] z_high;
    logic [31:0] z_low;

    int tests_run    = 0;
    int tests_failed = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .a_in        (a_in),
        .b_in        (b_in),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .z_high      (z_high),
        .z_low       (z_low)
    );

    always #5 clock = ~clock;

    // Reference: signed arithmetic on 64-bit values, truncating division.
    task automatic ref_model(input logic o, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] zh, output logic [31:0] zl,
                             output logic dz, output int lat);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        if (!o) begin
            p   = sa * sb;
            zh  = p[63:32];
            zl  = p[31:0];
            lat = 33;
        end else if (b == 32'd0) begin
            zh  = a;
            zl  = 32'hFFFF_FFFF;
            dz  = 1'b1;
            lat = 1;
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            zh  = r[31:0];
            zl  = q[31:0];
            lat = 34;
        end
    endtask

    // Issue one operation and measure: latency in cycles from the start edge to the
    // done cycle, results, busy/done overlap, and that done is a single-cycle pulse.
    task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                         input bit noise, output int lat,
                         output logic [31:0] zh, output logic [31:0] zl,
                         output logic dz, output bit bad_flags);
        @(negedge clock);
        op = o; a_in = a; b_in = b; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; a_in = $urandom; b_in = $urandom; op = 1'($urandom_range(0, 1));
        lat = -1; bad_flags = 1'b0; zh = 32'd0; zl = 32'd0; dz = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (busy && done) bad_flags = 1'b1;
            if (done) begin
                lat = n + 1; zh = z_high; zl = z_low; dz = div_by_zero;
                break;
            end
            if (!busy) bad_flags = 1'b1;
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                a_in  = $urandom;
                b_in  = $urandom;
                op    = 1'($urandom_range(0, 1));
            end
            @(posedge clock); #1;
        end
        start = 1'b0;
        @(posedge clock); #1;
        if (done || busy) bad_flags = 1'b1;
    endtask

    task automatic test_reset();
        clear = 1'b1; start = 1'b1; op = 1'b0; a_in = 32'd3; b_in = 32'd4;
        repeat (3) @(posedge clock);
        #1;
        tests_run++;
        if ({busy, done, div_by_zero} !== 3'b000 || z_high !== 32'd0 || z_low !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset: busy=%b done=%b dbz=%b zh=%h zl=%h, required all zero",
                     busy, done, div_by_zero, z_high, z_low);
        end
        clear = 1'b0; start = 1'b0;
        @(posedge clock); #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    // Directed cases with known results and latencies.
    task automatic test_directed();
        logic [31:0] va [6] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000, 32'd100};
        logic [31:0] vb [6] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
        logic        vo [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [31:0] xh [6] = '{32'hFFFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd2};
        logic [31:0] xl [6] = '{32'hFFFF_FFEB, 32'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF2};
        logic        xd [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int          xt [6] = '{33, 33, 34, 1, 34, 34};
        int lat; logic [31:0] zh, zl; logic dz; bit bad;
        for (int i = 0; i < 6; i++) begin
            do_op(vo[i], va[i], vb[i], 1'b0, lat, zh, zl, dz, bad);
            tests_run++;
            if (zh !== xh[i] || zl !== xl[i] || dz !== xd[i]) begin
                tests_failed++;
                $display("FAIL directed_%0d result: zh=%h zl=%h dbz=%b, required zh=%h zl=%h dbz=%b",
                         i, zh, zl, dz, xh[i], xl[i], xd[i]);
            end
            tests_run++;
            if (lat !== xt[i] || bad) begin
                tests_failed++;
                $display("FAIL directed_%0d timing: latency=%0d flags_bad=%b, required latency=%0d flags_bad=0",
                         i, lat, bad, xt[i]);
            end
        end
    endtask

    // Randomized mix against the reference model, with biased corner operands.
    task automatic test_random();
        int lat, elat; logic [31:0] zh, zl, eh, el, a, b; logic dz, ed, o; bit bad;
        for (int i = 0; i < 30; i++) begin
            o = 1'($urandom_range(0, 1));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: a = 32'h8000_0000;
                2: b = 32'hFFFF_FFFF;
                3: b = 32'($urandom_range(1, 9));
                4: a = 32'($urandom_range(0, 20)) - 32'd10;
                default: a = a;
            endcase
            ref_model(o, a, b, eh, el, ed, elat);
            do_op(o, a, b, 1'b0, lat, zh, zl, dz, bad);
            tests_run++;
            if (zh !== eh || zl !== el || dz !== ed || lat !== elat || bad) begin
                tests_failed++;
                $display("FAIL random_%0d op=%b a=%h b=%h: zh=%h zl=%h dbz=%b lat=%0d bad=%b, required zh=%h zl=%h dbz=%b lat=%0d",
                         i, o, a, b, zh, zl, dz, lat, bad, eh, el, ed, elat);
            end
        end
    endtask

    // clear in the middle of a MUL, preceded by a div-by-zero so the flag is set.
    task automatic test_clear_midway();
        int lat; logic [31:0] zh, zl; logic dz; bit bad;
        do_op(1'b1, 32'd9, 32'd0, 1'b0, lat, zh, zl, dz, bad);
        @(negedge clock);
        op = 1'b0; a_in = 32'h1234_5678; b_in = 32'h9ABC_DEF1; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        tests_run++;
        if (div_by_zero !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_clears_dbz: dbz=%b busy=%b, required 0 1", div_by_zero, busy);
        end
        repeat (9) @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || z_high !== 32'd0 || z_low !== 32'd0 || div_by_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_midway: busy=%b done=%b zh=%h zl=%h dbz=%b, required all zero",
                     busy, done, z_high, z_low, div_by_zero);
        end
        do_op(1'b0, 32'd6, 32'd7, 1'b0, lat, zh, zl, dz, bad);
        tests_run++;
        if (zl !== 32'd42 || zh !== 32'd0 || lat !== 33 || bad) begin
            tests_failed++;
            $display("FAIL after_clear: zh=%h zl=%h lat=%0d bad=%b, required zh=0 zl=2a lat=33",
                     zh, zl, lat, bad);
        end
    endtask

    // Spurious start pulses and changing operands during busy must not disturb the result.
    task automatic test_back_to_back();
        int lat, elat; logic [31:0] zh, zl, eh, el, a, b; logic dz, ed, o; bit bad;
        for (int i = 0; i < 6; i++) begin
            o = 1'(i % 2);
            a = $urandom; b = $urandom | 32'd1;
            ref_model(o, a, b, eh, el, ed, elat);
            do_op(o, a, b, 1'b1, lat, zh, zl, dz, bad);
            tests_run++;
            if (zh !== eh || zl !== el || dz !== ed || lat !== elat || bad) begin
                tests_failed++;
                $display("FAIL noisy_start_%0d op=%b a=%h b=%h: zh=%h zl=%h dbz=%b lat=%0d bad=%b, required zh=%h zl=%h dbz=%b lat=%0d",
                         i, o, a, b, zh, zl, dz, lat, bad, eh, el, ed, elat);
            end
            tests_run++;
            if (z_high !== eh || z_low !== el) begin
                tests_failed++;
                $display("FAIL hold_%0d: zh=%h zl=%h, required zh=%h zl=%h", i, z_high, z_low, eh, el);
            end
        end
    endtask

    initial begin
        clear = 1'b0; start = 1'b0; op = 1'b0; a_in = 32'd0; b_in = 32'd0;
        test_reset();
        test_directed();
        test_clear_midway();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
